// File: rtl/dsm_bitstream_modulator.sv
// dsm_bitstream_modulator: delta-sigma bitstream source, incremental 1st-order or free-running 2nd-order
module dsm_bitstream_modulator #(
   parameter int INPUT_BITS = 8,
   parameter int M = 16,
   parameter int ACC_BITS = INPUT_BITS + 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  type_dec,
   input  logic [INPUT_BITS-1:0] sample_in,
   input  logic                  sample_valid,
   output logic                  sample_ready,
   output logic                  bit_out,
   output logic                  bit_valid,
   output logic                  frame_start,
   output logic                  overload
);
   localparam int CW = (M > 1) ? $clog2(M) : 1;
   localparam int IW = ACC_BITS + 2;
   localparam logic signed [IW-1:0] HALF = IW'(2 ** (INPUT_BITS - 1));
   typedef enum logic {IDLE, RUN} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [INPUT_BITS:0] acc, s1, acc_n;
   logic signed [ACC_BITS-1:0] i1, i2, i1s, i2s;
   logic signed [IW-1:0] x, v, i1w, i2w;
   logic [INPUT_BITS-1:0] u_reg;
   logic type_q, type_chg, last, accept, b1, b2, ovf1, ovf2;
   always_comb begin
      type_chg = type_dec != type_q;
      last = cnt == CW'(M - 1);
      sample_ready = enable && !reset && !type_chg && (state == IDLE || last);
      accept = sample_ready && sample_valid;
      s1 = acc + {1'b0, u_reg};
      b1 = s1[INPUT_BITS];
      acc_n = {1'b0, s1[INPUT_BITS-1:0]};
      // second-order loop computed two bits wider, then clamped to the integrator range
      x = {{(IW-INPUT_BITS){1'b0}}, u_reg} - HALF;
      b2 = !i2[ACC_BITS-1];
      v = b2 ? HALF : -HALF;
      i1w = {{2{i1[ACC_BITS-1]}}, i1} + x - v;
      ovf1 = i1w[IW-1:ACC_BITS] != {2{i1w[ACC_BITS-1]}};
      i1s = ovf1 ? {i1w[IW-1], {(ACC_BITS-1){~i1w[IW-1]}}} : i1w[ACC_BITS-1:0];
      i2w = {{2{i2[ACC_BITS-1]}}, i2} + {{2{i1s[ACC_BITS-1]}}, i1s} - v;
      ovf2 = i2w[IW-1:ACC_BITS] != {2{i2w[ACC_BITS-1]}};
      i2s = ovf2 ? {i2w[IW-1], {(ACC_BITS-1){~i2w[IW-1]}}} : i2w[ACC_BITS-1:0];
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         acc <= '0;
         i1 <= '0;
         i2 <= '0;
         u_reg <= '0;
         type_q <= type_dec;
         bit_out <= 1'b0;
         bit_valid <= 1'b0;
         frame_start <= 1'b0;
         overload <= 1'b0;
      end else if (!enable) begin
         bit_valid <= 1'b0;
         frame_start <= 1'b0;
      end else if (type_chg) begin
         state <= IDLE;
         cnt <= '0;
         acc <= '0;
         i1 <= '0;
         i2 <= '0;
         overload <= 1'b0;
         bit_valid <= 1'b0;
         frame_start <= 1'b0;
         type_q <= type_dec;
      end else begin
         bit_valid <= state == RUN;
         frame_start <= state == RUN && cnt == '0;
         if (state == RUN) begin
            bit_out <= type_q ? b2 : b1;
            cnt <= last ? '0 : cnt + 1'b1;
            if (type_q) begin
               i1 <= i1s;
               i2 <= i2s;
               overload <= overload | ovf1 | ovf2;
            end else begin
               acc <= last ? '0 : acc_n;
            end
            if (last && !accept && !type_q) state <= IDLE;
         end
         if (accept) begin
            u_reg <= sample_in;
            state <= RUN;
         end
      end
   end
endmodule

// File: tb/tb_dsm_bitstream_modulator.sv
// tb_dsm_bitstream_modulator: directed checks of both modulator types, handshake, enable and reset
module tb_dsm_bitstream_modulator;
   logic clk = 1'b0, reset = 1'b1, enable = 1'b1, type_dec = 1'b0, sample_valid = 1'b0;
   logic [7:0] sample_in = 8'd0;
   logic sample_ready, bit_out, bit_valid, frame_start, overload;
   int n_cmp = 0, n_err = 0;
   always #5 clk = ~clk;
   dsm_bitstream_modulator #(.INPUT_BITS(8), .M(16), .ACC_BITS(12)) dut (
      .clk(clk), .reset(reset), .enable(enable), .type_dec(type_dec),
      .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
      .bit_out(bit_out), .bit_valid(bit_valid), .frame_start(frame_start), .overload(overload)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
      n_cmp++;
      assert (obs >= lo && obs <= hi) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      int ones, nv, nfs, acc, s, b, prev, nb;
      logic [7:0] pat;
      pat = 8'b1001_1001;
      repeat (2) @(negedge clk);
      chk("rst_bit_valid", bit_valid, 0);
      chk("rst_bit_out", bit_out, 0);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_overload", overload, 0);
      chk("rst_ready", sample_ready, 0);
      reset = 1'b0;
      #1 chk("idle_ready", sample_ready, 1);
      // type 1, u = 128, single sample
      sample_in = 8'd128; sample_valid = 1'b1;
      @(negedge clk); sample_valid = 1'b0;
      chk("t1_latency", bit_valid, 0);
      chk("t1_ready_run", sample_ready, 0);
      ones = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk("t1_valid", bit_valid, 1);
         chk("t1_bit", bit_out, k % 2);
         chk("t1_fs", frame_start, k == 0);
         chk("t1_ready", sample_ready, k >= 14);
         ones += int'(bit_out);
      end
      chk("t1_ones", ones, 8);
      @(negedge clk);
      chk("t1_idle_valid", bit_valid, 0);
      chk("t1_idle_ready", sample_ready, 1);
      // type 1 back-to-back: 255 then 0
      sample_in = 8'd255; sample_valid = 1'b1;
      @(negedge clk); sample_in = 8'd0;
      ones = 0;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         chk("b2b_valid", bit_valid, 1);
         chk("b2b_fs", frame_start, k % 16 == 0);
         chk("b2b_ready", sample_ready, (k % 16 == 14) || k == 31);
         if (k == 0) chk("b2b_first", bit_out, 0);
         if (k == 15) chk("b2b_last", bit_out, 1);
         ones += int'(bit_out);
         if (k == 15) begin chk("b2b_ones1", ones, 15); ones = 0; end
         if (k == 30) sample_valid = 1'b0;
      end
      chk("b2b_ones2", ones, 0);
      // enable dropped for 3 cycles at cnt = 7, u = 77
      sample_in = 8'd77; sample_valid = 1'b1;
      @(negedge clk); sample_valid = 1'b0;
      acc = 0; prev = 0;
      for (int k = 0; k < 16; k++) begin
         if (k == 7) begin
            enable = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("en_valid_low", bit_valid, 0);
               chk("en_fs_low", frame_start, 0);
               chk("en_hold", bit_out, prev);
               chk("en_ready_low", sample_ready, 0);
            end
            enable = 1'b1;
         end
         @(negedge clk);
         s = acc + 77; b = (s >= 256) ? 1 : 0; acc = s - b * 256;
         chk("en_bit", bit_out, b);
         chk("en_valid", bit_valid, 1);
         chk("en_fs", frame_start, k == 0);
         prev = b;
      end
      // asynchronous reset mid-frame, type 2 selected during reset
      sample_in = 8'd128; sample_valid = 1'b1;
      @(negedge clk); sample_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("ar_pre_bit", bit_out, 1);
      chk("ar_pre_valid", bit_valid, 1);
      #2 reset = 1'b1;
      #1;
      chk("ar_bit_out", bit_out, 0);
      chk("ar_bit_valid", bit_valid, 0);
      chk("ar_ready", sample_ready, 0);
      type_dec = 1'b1;
      @(negedge clk); reset = 1'b0;
      #1 chk("t2_idle_ready", sample_ready, 1);
      // type 2, u = 128
      sample_in = 8'd128; sample_valid = 1'b1;
      @(negedge clk); sample_valid = 1'b0;
      nv = 0; nfs = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (k < 8) chk("t2_pat", bit_out, pat[7-k]);
         nv += int'(bit_valid);
         nfs += int'(frame_start);
      end
      chk("t2_valid_cnt", nv, 1000);
      chk("t2_fs_cnt", nfs, 63);
      chk("t2_ovl_128", overload, 0);
      // type 2, u = 192 then u = 255, density checks
      sample_in = 8'd192; sample_valid = 1'b1; nb = 0;
      while (!sample_ready && nb < 40) begin @(negedge clk); nb++; end
      chk("t2_wait192", nb < 40, 1);
      @(negedge clk);
      ones = 0;
      repeat (4096) begin @(negedge clk); ones += int'(bit_out); end
      chk_rng("t2_ones192", ones, 3070, 3074);
      chk("t2_ovl_192", overload, 0);
      sample_in = 8'd255; nb = 0;
      while (!sample_ready && nb < 40) begin @(negedge clk); nb++; end
      chk("t2_wait255", nb < 40, 1);
      @(negedge clk);
      ones = 0;
      repeat (4096) begin @(negedge clk); ones += int'(bit_out); end
      chk_rng("t2_ones255", ones, 4072, 4088);
      // type flip 2 -> 1 at cnt = 5
      sample_valid = 1'b0; nb = 0;
      while (!frame_start && nb < 40) begin @(negedge clk); nb++; end
      chk("flip_wait_fs", nb < 40, 1);
      repeat (4) @(negedge clk);
      type_dec = 1'b0;
      @(negedge clk);
      chk("flip1_valid", bit_valid, 0);
      chk("flip1_ovl", overload, 0);
      chk("flip1_ready", sample_ready, 1);
      sample_in = 8'd200; sample_valid = 1'b1;
      @(negedge clk); sample_valid = 1'b0;
      chk("flip1_latency", bit_valid, 0);
      acc = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         s = acc + 200; b = (s >= 256) ? 1 : 0; acc = s - b * 256;
         chk("flip1_bit", bit_out, b);
         chk("flip1_fs", frame_start, k == 0);
      end
      // type flip 1 -> 2 at cnt = 5; restarted pattern shows integrators were cleared
      type_dec = 1'b1;
      @(negedge clk);
      chk("flip2_valid", bit_valid, 0);
      chk("flip2_ready", sample_ready, 1);
      sample_in = 8'd128; sample_valid = 1'b1;
      @(negedge clk); sample_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("flip2_pat", bit_out, pat[7-k]);
         chk("flip2_fs", frame_start, k == 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
